// File: rtl/atommc_responder.sv
// AtoMMC bus responder: Atom-side register file, command handshake and data FIFOs.
// Define ATOMMC_WRFIFO_EN for a 16-deep write FIFO; otherwise a 1-byte holding register.
module atommc_responder (
  input  logic       Sys_Clk,
  input  logic       Sys_Reset,
  input  logic [2:0] PIC_Addr,
  input  logic       PIC_nRD,
  input  logic       PIC_nWR,
  input  logic       PIC_nEn,
  input  logic [7:0] Bus_Din,
  output logic [7:0] Bus_Dout,
  output logic       Bus_Oe,
  output logic       Cmd_Valid,
  output logic [7:0] Cmd_Code,
  input  logic       Cmd_Ack,
  input  logic       Rsp_Valid,
  input  logic [7:0] Rsp_Data,
  output logic       Wf_Valid,
  output logic [7:0] Wf_Data,
  input  logic       Wf_Pop,
  input  logic       Rf_Push,
  input  logic [7:0] Rf_Data,
  output logic       Rf_Full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_WAIT
  } state_t;

  state_t state;

  logic [2:0] nrd_q;
  logic [2:0] nwr_q;
  logic       rd_ev;
  logic       wr_ev;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;

  logic       wr_cmd;
  logic       wr_latch;
  logic       wr_fifo;
  logic       rd_ok;
  logic       rd_stat;
  logic       rd_pop;

  logic [7:0] latch_r;
  logic [7:0] rsp_r;
  logic       cmd_err;
  logic       wf_ovf;
  logic       busy;
  logic [7:0] status;

  logic [7:0] rf_mem [16];
  logic [4:0] rf_wp;
  logic [4:0] rf_rp;
  logic       rf_empty;
  logic       rf_full;
  logic       rf_do_push;
  logic       rf_do_pop;
  logic [7:0] rf_head;

  logic       wf_empty;
  logic       wf_full;
  logic       wf_do_push;
  logic       wf_do_pop;

  // Two-stage synchronizers plus one extra stage for edge detection
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      nrd_q <= 3'b111;
      nwr_q <= 3'b111;
    end else begin
      nrd_q <= {nrd_q[1:0], PIC_nRD};
      nwr_q <= {nwr_q[1:0], PIC_nWR};
    end
  end

  assign rd_ev = nrd_q[1] & ~nrd_q[2];
  assign wr_ev = nwr_q[1] & ~nwr_q[2];

  // Capture address/data while a strobe is held low; events use the last sample
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      wr_addr <= 3'd0;
      wr_data <= 8'h00;
      rd_addr <= 3'd0;
    end else begin
      if (!nwr_q[1]) begin
        wr_addr <= PIC_Addr;
        wr_data <= Bus_Din;
      end
      if (!nrd_q[1]) begin
        rd_addr <= PIC_Addr;
      end
    end
  end

  assign wr_cmd   = wr_ev && (wr_addr == 3'd0);
  assign wr_latch = wr_ev && (wr_addr == 3'd1);
  assign wr_fifo  = wr_ev && (wr_addr == 3'd3);
  // A coincident write wins over a read
  assign rd_ok    = rd_ev && !wr_ev;
  assign rd_stat  = rd_ok && (rd_addr == 3'd4);
  assign rd_pop   = rd_ok && (rd_addr == 3'd2);

  assign busy   = (state != S_IDLE);
  assign status = {busy, cmd_err, wf_ovf, rf_empty, wf_full, 3'b000};

  // Read FIFO: 16 entries, extra pointer bit separates full from empty
  assign rf_empty   = (rf_wp == rf_rp);
  assign rf_full    = (rf_wp[3:0] == rf_rp[3:0]) && (rf_wp[4] != rf_rp[4]);
  assign rf_do_push = Rf_Push && !rf_full;
  assign rf_do_pop  = rd_pop && !rf_empty;
  assign rf_head    = rf_mem[rf_rp[3:0]];
  assign Rf_Full    = rf_full;

  // Read FIFO storage
  always_ff @(posedge Sys_Clk) begin
    if (rf_do_push) begin
      rf_mem[rf_wp[3:0]] <= Rf_Data;
    end
  end

  // Read FIFO pointers
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      rf_wp <= 5'd0;
      rf_rp <= 5'd0;
    end else begin
      if (rf_do_push) begin
        rf_wp <= rf_wp + 5'd1;
      end
      if (rf_do_pop) begin
        rf_rp <= rf_rp + 5'd1;
      end
    end
  end

  assign wf_do_pop = Wf_Pop && !wf_empty;

`ifdef ATOMMC_WRFIFO_EN
  logic [7:0] wf_mem [16];
  logic [4:0] wf_wp;
  logic [4:0] wf_rp;

  assign wf_empty   = (wf_wp == wf_rp);
  assign wf_full    = (wf_wp[3:0] == wf_rp[3:0]) && (wf_wp[4] != wf_rp[4]);
  assign wf_do_push = wr_fifo && !wf_full;
  assign Wf_Data    = wf_mem[wf_rp[3:0]];

  // Write FIFO storage
  always_ff @(posedge Sys_Clk) begin
    if (wf_do_push) begin
      wf_mem[wf_wp[3:0]] <= wr_data;
    end
  end

  // Write FIFO pointers
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      wf_wp <= 5'd0;
      wf_rp <= 5'd0;
    end else begin
      if (wf_do_push) begin
        wf_wp <= wf_wp + 5'd1;
      end
      if (wf_do_pop) begin
        wf_rp <= wf_rp + 5'd1;
      end
    end
  end
`else
  logic [7:0] wf_hold;
  logic       wf_vld;

  assign wf_empty   = !wf_vld;
  assign wf_full    = wf_vld;
  assign wf_do_push = wr_fifo && !wf_full;
  assign Wf_Data    = wf_hold;

  // Single-byte holding register behaving as a depth-1 FIFO
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      wf_hold <= 8'h00;
      wf_vld  <= 1'b0;
    end else begin
      if (wf_do_push) begin
        wf_hold <= wr_data;
        wf_vld  <= 1'b1;
      end else if (wf_do_pop) begin
        wf_vld  <= 1'b0;
      end
    end
  end
`endif

  assign Wf_Valid = !wf_empty;

  // Latch register and sticky error flags
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      latch_r <= 8'h00;
      cmd_err <= 1'b0;
      wf_ovf  <= 1'b0;
    end else begin
      if (wr_latch) begin
        latch_r <= wr_data;
      end
      if (wr_cmd && busy) begin
        cmd_err <= 1'b1;
      end else if (rd_stat) begin
        cmd_err <= 1'b0;
      end
      if (wr_fifo && wf_full) begin
        wf_ovf <= 1'b1;
      end else if (rd_stat) begin
        wf_ovf <= 1'b0;
      end
    end
  end

  // Command handshake FSM with registered outputs
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      state     <= S_IDLE;
      Cmd_Valid <= 1'b0;
      Cmd_Code  <= 8'h00;
      rsp_r     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_cmd) begin
            Cmd_Code  <= wr_data;
            Cmd_Valid <= 1'b1;
            state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (Cmd_Ack) begin
            Cmd_Valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (Rsp_Valid) begin
            rsp_r <= Rsp_Data;
            state <= S_IDLE;
          end
        end
        default: begin
          Cmd_Valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Read data mux, registered every cycle from the live address
  always_ff @(posedge Sys_Clk or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      Bus_Dout <= 8'hFF;
    end else begin
      case (PIC_Addr)
        3'd0:    Bus_Dout <= rsp_r;
        3'd1:    Bus_Dout <= latch_r;
        3'd2:    Bus_Dout <= rf_empty ? 8'hFF : rf_head;
        3'd4:    Bus_Dout <= status;
        default: Bus_Dout <= 8'hFF;
      endcase
    end
  end

  assign Bus_Oe = !PIC_nRD && !PIC_nEn;

endmodule

// File: tb/tb_atommc_responder.sv
// Testbench for atommc_responder: vector table, directed handshake/FIFO
// sequences and randomized bus traffic against a queue-based reference model.
module tb_atommc_responder;

`ifdef ATOMMC_WRFIFO_EN
  localparam int WF_DEPTH = 16;
`else
  localparam int WF_DEPTH = 1;
`endif
  localparam int RF_DEPTH = 16;

  logic       Sys_Clk = 1'b0;
  logic       Sys_Reset;
  logic [2:0] PIC_Addr;
  logic       PIC_nRD;
  logic       PIC_nWR;
  logic       PIC_nEn;
  logic [7:0] Bus_Din;
  logic [7:0] Bus_Dout;
  logic       Bus_Oe;
  logic       Cmd_Valid;
  logic [7:0] Cmd_Code;
  logic       Cmd_Ack;
  logic       Rsp_Valid;
  logic [7:0] Rsp_Data;
  logic       Wf_Valid;
  logic [7:0] Wf_Data;
  logic       Wf_Pop;
  logic       Rf_Push;
  logic [7:0] Rf_Data;
  logic       Rf_Full;

  int checks = 0;
  int failures = 0;

  atommc_responder dut (
    .Sys_Clk   (Sys_Clk),
    .Sys_Reset (Sys_Reset),
    .PIC_Addr  (PIC_Addr),
    .PIC_nRD   (PIC_nRD),
    .PIC_nWR   (PIC_nWR),
    .PIC_nEn   (PIC_nEn),
    .Bus_Din   (Bus_Din),
    .Bus_Dout  (Bus_Dout),
    .Bus_Oe    (Bus_Oe),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Code  (Cmd_Code),
    .Cmd_Ack   (Cmd_Ack),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Data  (Rsp_Data),
    .Wf_Valid  (Wf_Valid),
    .Wf_Data   (Wf_Data),
    .Wf_Pop    (Wf_Pop),
    .Rf_Push   (Rf_Push),
    .Rf_Data   (Rf_Data),
    .Rf_Full   (Rf_Full)
  );

  always #5 Sys_Clk = ~Sys_Clk;

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge Sys_Clk);
    PIC_Addr = a;
    Bus_Din  = d;
    PIC_nEn  = 1'b0;
    PIC_nWR  = 1'b0;
    repeat (4) @(negedge Sys_Clk);
    PIC_nWR  = 1'b1;
    PIC_nEn  = 1'b1;
    repeat (6) @(negedge Sys_Clk);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge Sys_Clk);
    PIC_Addr = a;
    PIC_nEn  = 1'b0;
    PIC_nRD  = 1'b0;
    repeat (4) @(negedge Sys_Clk);
    d = Bus_Dout;
    chk("bus_oe_rd", {7'b0, Bus_Oe}, 8'h01);
    PIC_nRD  = 1'b1;
    PIC_nEn  = 1'b1;
    repeat (6) @(negedge Sys_Clk);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic wf_pop(output logic v, output logic [7:0] d);
    @(negedge Sys_Clk);
    v = Wf_Valid;
    d = Wf_Data;
    Wf_Pop = 1'b1;
    @(negedge Sys_Clk);
    Wf_Pop = 1'b0;
  endtask

  task automatic rf_push(input logic [7:0] d);
    @(negedge Sys_Clk);
    Rf_Push = 1'b1;
    Rf_Data = d;
    @(negedge Sys_Clk);
    Rf_Push = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [7:0] d);
    @(negedge Sys_Clk);
    Rsp_Valid = 1'b1;
    Rsp_Data  = d;
    @(negedge Sys_Clk);
    Rsp_Valid = 1'b0;
  endtask

  initial begin
    vec_t       vecs [$];
    logic [7:0] wf_q [$];
    logic [7:0] rf_q [$];
    logic [7:0] latch_m;
    logic       ovf_m;
    logic [7:0] d;
    logic [7:0] exp;
    logic       v;
    int         op;

    Sys_Reset = 1'b1;
    PIC_Addr  = 3'd0;
    PIC_nRD   = 1'b1;
    PIC_nWR   = 1'b1;
    PIC_nEn   = 1'b1;
    Bus_Din   = 8'h00;
    Cmd_Ack   = 1'b0;
    Rsp_Valid = 1'b0;
    Rsp_Data  = 8'h00;
    Wf_Pop    = 1'b0;
    Rf_Push   = 1'b0;
    Rf_Data   = 8'h00;

    // reset state
    repeat (3) @(negedge Sys_Clk);
    chk("rst_dout", Bus_Dout, 8'hFF);
    chk("rst_cmd_valid", {7'b0, Cmd_Valid}, 8'h00);
    chk("rst_cmd_code", Cmd_Code, 8'h00);
    chk("rst_wf_valid", {7'b0, Wf_Valid}, 8'h00);
    chk("rst_rf_full", {7'b0, Rf_Full}, 8'h00);
    chk("rst_oe", {7'b0, Bus_Oe}, 8'h00);
    Sys_Reset = 1'b0;
    repeat (3) @(negedge Sys_Clk);

    // register map vectors
    vecs.push_back('{0, 3'd4, 8'h00, 8'h10, "stat_reset"});
    vecs.push_back('{1, 3'd1, 8'h5A, 8'h00, "wr_latch"});
    vecs.push_back('{0, 3'd1, 8'h00, 8'h5A, "rd_latch"});
    vecs.push_back('{0, 3'd4, 8'h00, 8'h10, "stat_after_latch"});
    vecs.push_back('{0, 3'd0, 8'h00, 8'h00, "rd_rsp_reset"});
    vecs.push_back('{0, 3'd2, 8'h00, 8'hFF, "rd_rf_empty"});
    vecs.push_back('{0, 3'd3, 8'h00, 8'hFF, "rd_addr3"});
    vecs.push_back('{0, 3'd5, 8'h00, 8'hFF, "rd_addr5"});
    vecs.push_back('{0, 3'd7, 8'h00, 8'hFF, "rd_addr7"});
    vecs.push_back('{1, 3'd2, 8'h33, 8'h00, "wr_addr2"});
    vecs.push_back('{1, 3'd6, 8'h44, 8'h00, "wr_addr6"});
    vecs.push_back('{0, 3'd1, 8'h00, 8'h5A, "rd_latch_kept"});
    vecs.push_back('{0, 3'd4, 8'h00, 8'h10, "stat_after_ign"});
    vecs.push_back('{1, 3'd1, 8'hA5, 8'h00, "wr_latch2"});
    vecs.push_back('{0, 3'd1, 8'h00, 8'hA5, "rd_latch2"});
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end
    end
    chk("no_cmd_from_ign", {7'b0, Cmd_Valid}, 8'h00);

    // response outside WAIT is ignored
    pulse_rsp(8'h77);
    rd_chk("rsp_idle_ignored", 3'd0, 8'h00);

    // command handshake
    bus_write(3'd0, 8'h20);
    chk("cmd_valid_set", {7'b0, Cmd_Valid}, 8'h01);
    chk("cmd_code", Cmd_Code, 8'h20);
    rd_chk("stat_offer", 3'd4, 8'h90);
    chk("cmd_valid_hold", {7'b0, Cmd_Valid}, 8'h01);
    @(negedge Sys_Clk);
    Cmd_Ack = 1'b1;
    @(negedge Sys_Clk);
    Cmd_Ack = 1'b0;
    chk("cmd_valid_drop", {7'b0, Cmd_Valid}, 8'h00);
    bus_write(3'd0, 8'h55);
    chk("cmd_code_kept", Cmd_Code, 8'h20);
    chk("cmd_valid_busy", {7'b0, Cmd_Valid}, 8'h00);
    rd_chk("stat_cmderr", 3'd4, 8'hD0);
    rd_chk("stat_cmderr_clr", 3'd4, 8'h90);
    pulse_rsp(8'hC3);
    rd_chk("stat_idle", 3'd4, 8'h10);
    rd_chk("rd_rsp", 3'd0, 8'hC3);
    chk("no_reissue", {7'b0, Cmd_Valid}, 8'h00);

    // write FIFO overflow and drain
    for (int i = 0; i <= WF_DEPTH; i++) begin
      d = 8'($urandom);
      if (wf_q.size() < WF_DEPTH) wf_q.push_back(d);
      bus_write(3'd3, d);
    end
    rd_chk("stat_wf_ovf", 3'd4, 8'h38);
    rd_chk("stat_ovf_clr", 3'd4, 8'h18);
    for (int i = 0; i < WF_DEPTH; i++) begin
      wf_pop(v, d);
      chk("wf_pop_valid", {7'b0, v}, 8'h01);
      chk("wf_pop_data", d, wf_q.pop_front());
    end
    @(negedge Sys_Clk);
    chk("wf_empty", {7'b0, Wf_Valid}, 8'h00);
    wf_pop(v, d);
    rd_chk("stat_wf_drained", 3'd4, 8'h10);

    // read FIFO basics
    rd_chk("rf_empty_ff", 3'd2, 8'hFF);
    rf_push(8'h11);
    rf_push(8'h22);
    rd_chk("rf_rd_11", 3'd2, 8'h11);
    rd_chk("rf_rd_22", 3'd2, 8'h22);
    rd_chk("rf_rd_empty", 3'd2, 8'hFF);

    // read FIFO full boundary and wrap
    for (int i = 0; i < RF_DEPTH; i++) rf_push(8'(8'h40 + i));
    chk("rf_full", {7'b0, Rf_Full}, 8'h01);
    rf_push(8'hEE);
    rd_chk("stat_rf_full", 3'd4, 8'h00);
    for (int i = 0; i < RF_DEPTH; i++) begin
      rd_chk("rf_drain", 3'd2, 8'(8'h40 + i));
    end
    chk("rf_not_full", {7'b0, Rf_Full}, 8'h00);
    rd_chk("rf_drained", 3'd2, 8'hFF);

    // randomized traffic against queue model
    latch_m = 8'h3C;
    bus_write(3'd1, latch_m);
    ovf_m = 1'b0;
    for (int n = 0; n < 160; n++) begin
      op = int'($urandom_range(0, 8));
      case (op)
        0: begin
          d = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            bus_write(3'($urandom_range(4, 7)), d);
          end else begin
            bus_write(3'd1, d);
            latch_m = d;
          end
        end
        1, 2: begin
          d = 8'($urandom);
          if (wf_q.size() < WF_DEPTH) wf_q.push_back(d);
          else ovf_m = 1'b1;
          bus_write(3'd3, d);
        end
        3: begin
          if ($urandom_range(0, 1) == 0) begin
            rd_chk("rnd_latch", 3'd1, latch_m);
          end else begin
            rd_chk("rnd_unmapped", 3'd5, 8'hFF);
          end
        end
        4: begin
          exp = {1'b0, 1'b0, ovf_m, rf_q.size() == 0,
                 wf_q.size() == WF_DEPTH, 3'b000};
          rd_chk("rnd_status", 3'd4, exp);
          ovf_m = 1'b0;
        end
        5: begin
          exp = (rf_q.size() != 0) ? rf_q.pop_front() : 8'hFF;
          rd_chk("rnd_rf_read", 3'd2, exp);
        end
        6, 8: begin
          chk("rnd_rf_full", {7'b0, Rf_Full},
              {7'b0, rf_q.size() == RF_DEPTH});
          d = 8'($urandom);
          if (rf_q.size() < RF_DEPTH) rf_q.push_back(d);
          rf_push(d);
        end
        default: begin
          wf_pop(v, d);
          chk("rnd_wf_valid", {7'b0, v}, {7'b0, wf_q.size() != 0});
          if (wf_q.size() != 0) chk("rnd_wf_data", d, wf_q.pop_front());
        end
      endcase
    end

    // reset in the middle of a command offer
    bus_write(3'd0, 8'h42);
    chk("offer_before_rst", {7'b0, Cmd_Valid}, 8'h01);
    @(negedge Sys_Clk);
    Sys_Reset = 1'b1;
    #1;
    chk("rst_async_valid", {7'b0, Cmd_Valid}, 8'h00);
    chk("rst_async_code", Cmd_Code, 8'h00);
    repeat (2) @(negedge Sys_Clk);
    Sys_Reset = 1'b0;
    repeat (6) @(negedge Sys_Clk);
    chk("rst_no_reissue", {7'b0, Cmd_Valid}, 8'h00);
    chk("rst_wf_empty", {7'b0, Wf_Valid}, 8'h00);
    rd_chk("rst_status", 3'd4, 8'h10);
    rd_chk("rst_latch", 3'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atommc_responder.md
ATOMMC_RESPONDER -- requirements
Module: atommc_responder

Interface
REQ-001 Sys_Clk  in  1  system clock; all state on rising edge; frequency >= 16x Atom_Phi2.
REQ-002 Sys_Reset  in  1  asynchronous, active-high reset.
REQ-003 PIC_Addr  in  3  register select from the Atom-side decoder, latched there on writes.
REQ-004 PIC_nRD / PIC_nWR / PIC_nEn  in  1 each  active-low strobes, asynchronous to Sys_Clk.
REQ-005 Bus_Din  in  8  Atom data bus; valid while PIC_nWR is low.
REQ-006 Bus_Dout  out  8  read data; Bus_Oe  out  1  high while PIC_nRD and PIC_nEn are both low.
REQ-007 Cmd_Valid  out  1; Cmd_Code  out  8; Cmd_Ack  in  1  command handshake to the controller.
REQ-008 Rsp_Valid  in  1; Rsp_Data  in  8  one-cycle response pulse from the controller.
REQ-009 Wf_Valid  out  1; Wf_Data  out  8; Wf_Pop  in  1  write-data FIFO, read by the controller.
REQ-010 Rf_Push  in  1; Rf_Data  in  8; Rf_Full  out  1  read-data FIFO, filled by the controller.

Function
REQ-011 PIC_nRD and PIC_nWR each pass through a 2-FF synchronizer; a strobe event is the synchronized low-to-high edge.
REQ-012 While the synchronized PIC_nWR is low, PIC_Addr and Bus_Din are sampled every cycle; a write event uses the last sample taken.
REQ-013 Write map: 0 = command, 1 = latch register, 3 = write-FIFO push; addresses 2 and 4-7 are ignored.
REQ-014 Read map: 0 = response register, 1 = latch register, 2 = read-FIFO head, 4 = status; addresses 3 and 5-7 read 0xFF.
REQ-015 Bus_Dout is a registered mux of PIC_Addr and updates every cycle.
REQ-016 Status byte: bit7 Busy, bit6 CmdErr, bit5 WfOvf, bit4 Rf empty, bit3 Wf full, bits2-0 zero.
REQ-017 Command FSM states: IDLE -> OFFER, on a write to address 0 (Cmd_Code <= data, Cmd_Valid = 1).
REQ-018 OFFER -> WAIT on Cmd_Ack (Cmd_Valid drops next cycle); WAIT -> IDLE on Rsp_Valid (response register <= Rsp_Data).
REQ-019 Busy = 1 in OFFER and WAIT; Rsp_Valid outside WAIT is ignored.
REQ-020 A write to address 0 while Busy is dropped and sets CmdErr (sticky).
REQ-021 A read event at address 4 clears CmdErr and WfOvf, both one cycle after the event.
REQ-022 A read event at address 2 pops the read FIFO; if empty, the read returns 0xFF and the pointers are unchanged.
REQ-023 Read FIFO: depth 16, 5-bit pointers, wraps modulo 16; Rf_Push while Rf_Full is dropped.
REQ-024 A push to a full write FIFO is dropped and sets WfOvf; Wf_Pop while empty is ignored.
REQ-025 A simultaneous push and pop on either FIFO performs both; occupancy is unchanged.
REQ-026 A read and a write event never coincide; if they do, the write is processed and the read is ignored.

Reset
REQ-027 On Sys_Reset: FSM IDLE, both FIFOs empty, latch, response and Cmd_Code 0x00, CmdErr and WfOvf 0.
REQ-028 On Sys_Reset: Cmd_Valid 0, Wf_Valid 0, Rf_Full 0, Bus_Dout 0xFF, synchronizers 1.
REQ-029 Reset during OFFER or WAIT abandons the command; no Cmd_Valid is issued after release.

Configuration
REQ-030 With ATOMMC_WRFIFO_EN defined, the write-data path is a 16-deep FIFO as specified above.
REQ-031 Without ATOMMC_WRFIFO_EN, the write-data path is a single-byte holding register (depth 1) with the same full, empty and overflow semantics.

Verification
REQ-032 Write 0x5A to address 1, then read address 1 -> Bus_Dout 0x5A; status read -> 0x10.
REQ-033 Write 0x20 to address 0 -> Cmd_Valid=1, Cmd_Code=0x20, status bit7=1; Cmd_Ack then Rsp_Valid with 0x00 -> status 0x10, address 0 reads 0x00.
REQ-034 Second write to address 0 while in WAIT -> Cmd_Code unchanged; status 0xD0; a repeat status read returns 0x90.
REQ-035 17 writes to address 3 with the FIFO enabled -> status bits 5 and 3 set; 16 Wf_Pops return the first 16 bytes in order.
REQ-036 Read address 2 with the read FIFO empty -> 0xFF; push 0x11 and 0x22 -> successive reads return 0x11, 0x22, then 0xFF.
REQ-037 Assert Sys_Reset mid-OFFER -> Cmd_Valid 0 immediately, status 0x10 after release.
